sram_ctrl: RTL

Synchronous controller that converts single-word valid/ready read and write requests into correctly sequenced strobes for the asynchronous 8-bit SRAM. It sits directly upstream of the SRAM: the processor bus side drives requests, and this block owns the SRAM address, data, chip-select, write-enable and output-enable pins. Every access is a fixed sequence of setup, strobe, hold and idle phases, so address and data stay stable around each strobe.

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_strobe_timer.sv | 26 ++
 rtl/sram_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access sequencer: state encodings and strobe counter width.
package sram_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_strobe_timer.sv
// Strobe-width down-counter: load on entry to STROBE, count down to zero and stop there.
module sram_strobe_timer
  import sram_ctrl_pkg::*;
(
  input  logic CLK,
  input  logic RST_bar,
  input  logic load,
  input  cnt_t load_val,
  output logic zero
);

  cnt_t cnt;

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - cnt_t'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready to asynchronous 8-bit SRAM sequencer (setup, strobe, hold, idle).
// Build option: SRAM_CTRL_WRITE_ACK_EN makes writes pulse rsp_valid in HOLD as reads do.
//
//   state  | meaning
//   IDLE   | strobes high, req_ready high, waiting for a request
//   SETUP  | CS_bar low, address/data settling before the strobe
//   STROBE | WE_bar (write) or OE_bar (read) low for WAIT_STATES+1 cycles
//   HOLD   | strobe released, CS_bar still low, response pulse
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  RST_bar,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [7:0]            MEM_D,
  input  logic [7:0]            MEM_Q,
  output logic                  MEM_CS_bar,
  output logic                  MEM_WE_bar,
  output logic                  MEM_OE_bar
);

`ifdef SRAM_CTRL_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  state_t state, state_nxt;
  logic   we_q;
  logic   accept;
  logic   cnt_zero;
  logic   strobe_done;
  logic   cs_bar_nxt, we_bar_nxt, oe_bar_nxt;

  assign req_ready   = (state == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign strobe_done = (state == ST_STROBE) && cnt_zero;

  sram_strobe_timer u_timer (
    .CLK      (CLK),
    .RST_bar  (RST_bar),
    .load     (state == ST_SETUP),
    .load_val (cnt_t'(WAIT_STATES)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobe levels are decoded from the next state so the pins themselves are flops.
  always_comb begin
    state_nxt  = state;
    cs_bar_nxt = 1'b1;
    we_bar_nxt = 1'b1;
    oe_bar_nxt = 1'b1;
    unique case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_STROBE;
      ST_STROBE: if (cnt_zero) state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (state_nxt != ST_IDLE) cs_bar_nxt = 1'b0;
    if (state_nxt == ST_STROBE) begin
      we_bar_nxt = !we_q;
      oe_bar_nxt = we_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      we_q       <= 1'b0;
      MEM_A      <= '0;
      MEM_D      <= '0;
      MEM_CS_bar <= 1'b1;
      MEM_WE_bar <= 1'b1;
      MEM_OE_bar <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      if (accept) begin
        we_q  <= req_we;
        MEM_A <= req_addr;
        MEM_D <= req_wdata;
      end
      MEM_CS_bar <= cs_bar_nxt;
      MEM_WE_bar <= we_bar_nxt;
      MEM_OE_bar <= oe_bar_nxt;
      rsp_valid  <= strobe_done && (!we_q || WRITE_ACK);
      if (strobe_done && !we_q) rsp_rdata <= MEM_Q;
    end
  end

endmodule
